// File: rtl/mm_sched_pkg.sv
// Shared types and sizing helpers for the mm systolic-array control sequencer.
package mm_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, SEND} state_t;
    typedef enum logic [1:0] {CLR, FEED, SKEW, UNLOAD} phase_t;

    function automatic int tile_cycles(input int m, input int n1, input int n2);
        return 2 * n1 + n2 + m - 1;
    endfunction

    function automatic int num_tiles(input int m, input int n1, input int n2);
        return (m / n1) * (m / n2);
    endfunction

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mm_sched_if.sv
// Operand-in and result-out stream handshakes of the mm sequencer.
interface mm_sched_if;
    logic s_tvalid;
    logic s_tlast;
    logic s_tready;
    logic m_tvalid;
    logic m_tlast;
    logic m_tready;

    modport slave  (input  s_tvalid, s_tlast, m_tready,
                    output s_tready, m_tvalid, m_tlast);
    modport master (output s_tvalid, s_tlast, m_tready,
                    input  s_tready, m_tvalid, m_tlast);
endinterface

// File: rtl/mm_tile_seq.sv
// Per-tile phase sequencer: CLR, FEED (M cycles), SKEW (N1+N2-2), UNLOAD (N1 rows).
module mm_tile_seq
    import mm_pkg::*;
#(
    parameter int M  = 8,
    parameter int N1 = 4,
    parameter int N2 = 4
) (
    input  logic                         mm_clk,
    input  logic                         mm_rst,
    input  logic                         start,
    output logic                         arr_clr,
    output logic                         arr_en,
    output logic [clog2_min1(M)-1:0]     k_idx,
    output logic                         res_wr_en,
    output logic [clog2_min1(N1)-1:0]    r,
    output logic                         tile_done
);
    localparam int KW       = clog2_min1(M);
    localparam int RW       = clog2_min1(N1);
    localparam int SKEW_LEN = N1 + N2 - 2;
    localparam int CNTW     = clog2_min1(M + N1 + N2);
    localparam logic [CNTW-1:0] FEED_LAST   = CNTW'(M - 1);
    localparam logic [CNTW-1:0] SKEW_LAST   = CNTW'((SKEW_LEN > 0) ? SKEW_LEN - 1 : 0);
    localparam logic [CNTW-1:0] UNLOAD_LAST = CNTW'(N1 - 1);

    phase_t          phase_reg;
    logic            active_reg;
    logic [CNTW-1:0] cnt_reg;

    // A start coinciding with the last UNLOAD cycle chains straight into the next tile.
    always_ff @(posedge mm_clk) begin
        if (mm_rst) begin
            active_reg <= 1'b0;
            phase_reg  <= CLR;
            cnt_reg    <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            phase_reg  <= CLR;
            cnt_reg    <= '0;
        end else if (active_reg) begin
            case (phase_reg)
                CLR: begin
                    phase_reg <= FEED;
                    cnt_reg   <= '0;
                end
                FEED: begin
                    if (cnt_reg == FEED_LAST) begin
                        phase_reg <= (SKEW_LEN > 0) ? SKEW : UNLOAD;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                SKEW: begin
                    if (cnt_reg == SKEW_LAST) begin
                        phase_reg <= UNLOAD;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (cnt_reg == UNLOAD_LAST) begin
                        active_reg <= 1'b0;
                        phase_reg  <= CLR;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: phase_reg <= CLR;
            endcase
        end
    end

    assign arr_clr   = active_reg && (phase_reg == CLR);
    assign arr_en    = active_reg && (phase_reg == FEED);
    assign res_wr_en = active_reg && (phase_reg == UNLOAD);
    assign k_idx     = arr_en ? KW'(cnt_reg) : '0;
    assign r         = res_wr_en ? RW'(cnt_reg) : '0;
    assign tile_done = res_wr_en && (cnt_reg == UNLOAD_LAST);

endmodule

// File: rtl/mm_sched.sv
// Top-level sequencer: operand load, tiled compute walk, and result streaming.
module mm_sched
    import mm_pkg::*;
#(
    parameter int D_W = 8,
    parameter int N1  = 4,
    parameter int N2  = 4,
    parameter int M   = 8
) (
    input  logic                            mm_clk,
    input  logic                            mm_rst,
    mm_sched_if.slave                       strm,
    output logic                            in_wr_en,
    output logic                            in_wr_sel,
    output logic [$clog2(M*M)-1:0]          in_wr_addr,
    output logic                            arr_clr,
    output logic                            arr_en,
    output logic [clog2_min1(M)-1:0]        k_idx,
    output logic [clog2_min1(M/N1)-1:0]     ti,
    output logic [clog2_min1(M/N2)-1:0]     tj,
    output logic                            res_wr_en,
    output logic [clog2_min1(M)-1:0]        res_row,
    output logic [clog2_min1(M)-1:0]        res_col,
    output logic [$clog2(M*M)-1:0]          out_rd_addr,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);
    localparam int MM  = M * M;
    localparam int AW  = $clog2(MM);
    localparam int KW  = clog2_min1(M);
    localparam int RW  = clog2_min1(N1);
    localparam int TIW = clog2_min1(M / N1);
    localparam int TJW = clog2_min1(M / N2);
    localparam int CW  = $clog2(2 * MM);
    localparam logic [CW-1:0]  LOAD_LAST = CW'(2 * MM - 1);
    localparam logic [CW-1:0]  SEND_LAST = CW'(MM - 1);
    localparam logic [CW-1:0]  B_BASE    = CW'(MM);
    localparam logic [TIW-1:0] TI_LAST   = TIW'(M / N1 - 1);
    localparam logic [TJW-1:0] TJ_LAST   = TJW'(M / N2 - 1);

    if ((M % N1) != 0 || (M % N2) != 0 || D_W < 1) begin : g_bad_params
        $fatal(1, "mm_sched: M must be a multiple of both N1 and N2");
    end

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [TIW-1:0] ti_reg;
    logic [TJW-1:0] tj_reg;
    logic           err_reg;
    logic           done_reg;

    logic          accept;
    logic          last_tile;
    logic          tile_start;
    logic          tile_done;
    logic [RW-1:0] r;

    assign accept     = strm.s_tvalid && strm.s_tready;
    assign last_tile  = (ti_reg == TI_LAST) && (tj_reg == TJ_LAST);
    // Tile 0 starts on the edge that leaves LOAD, so CLR lands on the first COMPUTE cycle.
    assign tile_start = (accept && (cnt_reg == LOAD_LAST))
                     || ((state_reg == COMPUTE) && tile_done && !last_tile);

    mm_tile_seq #(.M(M), .N1(N1), .N2(N2)) u_tile_seq (
        .mm_clk    (mm_clk),
        .mm_rst    (mm_rst),
        .start     (tile_start),
        .arr_clr   (arr_clr),
        .arr_en    (arr_en),
        .k_idx     (k_idx),
        .res_wr_en (res_wr_en),
        .r         (r),
        .tile_done (tile_done)
    );

    always_ff @(posedge mm_clk) begin
        if (mm_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ti_reg    <= '0;
            tj_reg    <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (strm.s_tvalid) begin
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt_reg == LOAD_LAST) begin
                            state_reg <= COMPUTE;
                            cnt_reg   <= '0;
                            ti_reg    <= '0;
                            tj_reg    <= '0;
                            if (!strm.s_tlast) err_reg <= 1'b1;
                        end else if (strm.s_tlast) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            err_reg   <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (tile_done) begin
                        if (last_tile) begin
                            state_reg <= SEND;
                            cnt_reg   <= '0;
                            ti_reg    <= '0;
                            tj_reg    <= '0;
                        end else if (tj_reg == TJ_LAST) begin
                            tj_reg <= '0;
                            ti_reg <= ti_reg + 1'b1;
                        end else begin
                            tj_reg <= tj_reg + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (strm.m_tready) begin
                        if (cnt_reg == SEND_LAST) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            done_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign strm.s_tready = (state_reg == LOAD);
    assign strm.m_tvalid = (state_reg == SEND);
    assign strm.m_tlast  = (state_reg == SEND) && (cnt_reg == SEND_LAST);

    assign in_wr_en    = accept;
    assign in_wr_sel   = (state_reg == LOAD) && (cnt_reg >= B_BASE);
    assign in_wr_addr  = (state_reg != LOAD) ? '0
                       : in_wr_sel ? AW'(cnt_reg - B_BASE) : AW'(cnt_reg);
    assign out_rd_addr = (state_reg == SEND) ? AW'(cnt_reg) : '0;

    assign ti      = ti_reg;
    assign tj      = tj_reg;
    assign res_row = res_wr_en ? KW'(int'(ti_reg) * N1 + int'(r)) : '0;
    assign res_col = res_wr_en ? KW'(int'(tj_reg) * N2) : '0;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_mm_sched.sv
// Randomized bench for mm_sched against a cycle-level transaction scoreboard.
module tb_mm_sched;
    localparam int M   = 8;
    localparam int N1  = 4;
    localparam int N2  = 4;
    localparam int MM  = M * M;
    localparam int AW  = 6;
    localparam int KW  = 3;
    localparam int TIW = 1;
    localparam int TJW = 1;
    localparam int T   = 2 * N1 + N2 + M - 1;
    localparam int NT  = (M / N1) * (M / N2);
    localparam int M_IDLE = 0, M_LOAD = 1, M_COMP = 2, M_SEND = 3;

    typedef struct packed {
        logic           s_rdy;
        logic           wr_en;
        logic           wr_sel;
        logic [AW-1:0]  wr_addr;
        logic           clr;
        logic           en;
        logic [KW-1:0]  k;
        logic [TIW-1:0] ti;
        logic [TJW-1:0] tj;
        logic           res_wr;
        logic [KW-1:0]  row;
        logic [KW-1:0]  col;
        logic           mv;
        logic           ml;
        logic [AW-1:0]  rd;
        logic           busy;
        logic           done;
        logic           err;
    } obs_t;

    logic clk;
    logic mm_rst;
    logic in_wr_en, in_wr_sel, arr_clr, arr_en, res_wr_en, busy, done, err;
    logic [AW-1:0]  in_wr_addr, out_rd_addr;
    logic [KW-1:0]  k_idx, res_row, res_col;
    logic [TIW-1:0] ti;
    logic [TJW-1:0] tj;

    mm_sched_if ifc();

    mm_sched #(.D_W(8), .N1(N1), .N2(N2), .M(M)) dut (
        .mm_clk(clk), .mm_rst(mm_rst), .strm(ifc),
        .in_wr_en(in_wr_en), .in_wr_sel(in_wr_sel), .in_wr_addr(in_wr_addr),
        .arr_clr(arr_clr), .arr_en(arr_en), .k_idx(k_idx), .ti(ti), .tj(tj),
        .res_wr_en(res_wr_en), .res_row(res_row), .res_col(res_col),
        .out_rd_addr(out_rd_addr), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   done_cnt  = 0;
    int   jobs_seen = 0;
    bit   ready_rand = 1'b0;
    obs_t trace[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        check_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    function automatic string mode_name(input int md);
        case (md)
            M_LOAD:  return "load";
            M_COMP:  return "compute";
            M_SEND:  return "send";
            default: return "idle";
        endcase
    endfunction

    function automatic logic [63:0] raw_outputs();
        return 64'({ifc.s_tready, in_wr_en, in_wr_sel, in_wr_addr, arr_clr, arr_en, k_idx,
                    ti, tj, res_wr_en, res_row, res_col, ifc.m_tvalid, ifc.m_tlast,
                    out_rd_addr, busy, done, err});
    endfunction

    // Expected compute trace, built tile by tile from the phase lengths.
    initial begin
        for (int a = 0; a < M / N1; a++)
            for (int b = 0; b < M / N2; b++)
                for (int o = 0; o < T; o++) begin
                    obs_t e;
                    e = '0;
                    e.ti = TIW'(a);
                    e.tj = TJW'(b);
                    if (o == 0) e.clr = 1'b1;
                    else if (o <= M) begin
                        e.en = 1'b1;
                        e.k  = KW'(o - 1);
                    end else if (o >= M + N1 + N2 - 1) begin
                        e.res_wr = 1'b1;
                        e.row    = KW'(a * N1 + o - (M + N1 + N2 - 1));
                        e.col    = KW'(b * N2);
                    end
                    trace.push_back(e);
                end
    end

    // Scoreboard: mirrors the job-level rules and compares every cycle.
    initial begin
        int   mode = M_IDLE;
        int   load_idx = 0, send_idx = 0, trace_idx = 0;
        int   cyc = 0, last_load_cyc = 0;
        bit   err_exp = 1'b0, done_exp = 1'b0, first_send = 1'b0;
        obs_t obs, exp;
        forever begin
            @(negedge clk);
            cyc++;
            obs = '0;
            obs.s_rdy = ifc.s_tready;
            obs.wr_en = in_wr_en;
            if (in_wr_en) begin obs.wr_sel = in_wr_sel; obs.wr_addr = in_wr_addr; end
            obs.clr = arr_clr;
            obs.en  = arr_en;
            if (arr_en) obs.k = k_idx;
            if (mode == M_COMP) begin obs.ti = ti; obs.tj = tj; end
            obs.res_wr = res_wr_en;
            if (res_wr_en) begin obs.row = res_row; obs.col = res_col; end
            obs.mv = ifc.m_tvalid;
            obs.ml = ifc.m_tlast;
            if (ifc.m_tvalid) obs.rd = out_rd_addr;
            obs.busy = busy;
            obs.done = done;
            obs.err  = err;
            if (done) done_cnt++;

            exp = '0;
            case (mode)
                M_LOAD: begin
                    exp.s_rdy = 1'b1;
                    exp.busy  = 1'b1;
                    exp.wr_en = ifc.s_tvalid;
                    if (ifc.s_tvalid) begin
                        exp.wr_sel  = (load_idx >= MM);
                        exp.wr_addr = AW'(load_idx % MM);
                    end
                end
                M_COMP: begin
                    exp = trace[trace_idx];
                    exp.busy = 1'b1;
                end
                M_SEND: begin
                    exp.busy = 1'b1;
                    exp.mv   = 1'b1;
                    exp.ml   = (send_idx == MM - 1);
                    exp.rd   = AW'(send_idx);
                end
                default: ;
            endcase
            exp.done = done_exp;
            exp.err  = err_exp;
            check(mode_name(mode), 64'(obs), 64'(exp));
            done_exp = 1'b0;

            case (mode)
                M_IDLE: if (ifc.s_tvalid) begin
                    mode = M_LOAD; load_idx = 0; err_exp = 1'b0;
                end
                M_LOAD: if (ifc.s_tvalid) begin
                    if (load_idx == 2 * MM - 1) begin
                        if (!ifc.s_tlast) err_exp = 1'b1;
                        mode = M_COMP; trace_idx = 0; last_load_cyc = cyc;
                    end else if (ifc.s_tlast) begin
                        err_exp = 1'b1; mode = M_IDLE;
                    end else load_idx++;
                end
                M_COMP: begin
                    trace_idx++;
                    if (trace_idx == trace.size()) begin
                        mode = M_SEND; send_idx = 0; first_send = 1'b1;
                    end
                end
                M_SEND: begin
                    if (first_send) begin
                        check("send_latency", 64'(cyc - last_load_cyc), 64'(T * NT + 1));
                        first_send = 1'b0;
                    end
                    if (ifc.m_tready) begin
                        if (send_idx == MM - 1) begin
                            mode = M_IDLE; done_exp = 1'b1; jobs_seen++;
                            $display("job %0d: %0d operand beats, %0d result beats, first result %0d cycles after last operand",
                                     jobs_seen, 2 * MM, MM, T * NT + 1);
                        end else send_idx++;
                    end
                end
                default: ;
            endcase
            if (mm_rst) begin
                mode = M_IDLE; err_exp = 1'b0; done_exp = 1'b0; first_send = 1'b0;
            end
        end
    end

    initial begin
        ifc.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 ifc.m_tready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic run_job(input int bad_beat, input bit gaps);
        int beat = 0;
        int guard = 0;
        while (beat < 2 * MM) begin
            @(posedge clk);
            #1;
            if (gaps && $urandom_range(0, 1) == 1) begin
                ifc.s_tvalid = 1'b0; ifc.s_tlast = 1'b0;
            end else begin
                ifc.s_tvalid = 1'b1;
                ifc.s_tlast  = (beat == 2 * MM - 1) || (beat == bad_beat);
            end
            @(negedge clk);
            if (ifc.s_tvalid && ifc.s_tready) beat = (beat == bad_beat) ? 2 * MM : beat + 1;
            guard++;
            if (guard > 3000) begin
                check("load_timeout", 64'(beat), 64'(2 * MM));
                break;
            end
        end
    endtask

    task automatic drop_inputs();
        @(posedge clk);
        #1 ifc.s_tvalid = 1'b0; ifc.s_tlast = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(target));
    endtask

    task automatic pulse_reset_and_check(input string tag);
        @(posedge clk);
        #1 mm_rst = 1'b1;
        @(posedge clk);
        #1 mm_rst = 1'b0;
        @(negedge clk);
        check(tag, raw_outputs(), 64'd0);
    endtask

    initial begin
        int n;
        mm_rst = 1'b1;
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1 mm_rst = 1'b0;
        @(negedge clk);
        check("reset_state", raw_outputs(), 64'd0);

        // Clean job, no back-pressure
        run_job(-1, 1'b0);
        drop_inputs();
        wait_done(1);
        check("err_clean", 64'(err), 64'd0);

        // Random gaps on both streams
        ready_rand = 1'b1;
        run_job(-1, 1'b1);
        drop_inputs();
        wait_done(2);
        ready_rand = 1'b0;

        // Early s_tlast on beat 40, then a clean job
        run_job(40, 1'b0);
        drop_inputs();
        repeat (20) @(negedge clk);
        check("err_early_tlast", 64'(err), 64'd1);
        check("busy_after_abort", 64'(busy), 64'd0);
        run_job(-1, 1'b0);
        drop_inputs();
        wait_done(3);
        check("err_cleared", 64'(err), 64'd0);

        // Reset inside the third tile
        run_job(-1, 1'b0);
        drop_inputs();
        repeat (2 * T + 2) @(posedge clk);
        pulse_reset_and_check("rst_mid_compute");

        // Reset during SEND around address 20
        run_job(-1, 1'b0);
        drop_inputs();
        n = 0;
        while (!(ifc.m_tvalid && out_rd_addr == AW'(20)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_send_20", 64'(n < 2000), 64'd1);
        pulse_reset_and_check("rst_mid_send");
        repeat (10) @(negedge clk);
        check("no_done_after_rst", 64'(done_cnt), 64'd3);
        run_job(-1, 1'b0);
        drop_inputs();
        wait_done(4);

        // Two jobs back to back with s_tvalid held high between them
        run_job(-1, 1'b0);
        run_job(-1, 1'b0);
        drop_inputs();
        wait_done(6);
        repeat (20) @(negedge clk);
        check("two_done_pulses", 64'(done_cnt), 64'd6);
        check("final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
